// File: rtl/constraint_sweeper_pkg.sv
// Shared types and constants for the chain relaxation sweeper.
// Coordinates are signed 32-bit fixed point with 16 fractional bits.
package constraint_sweeper_pkg;

  localparam int COORD_W   = 32;
  localparam int FRAC_BITS = 16;

  // Rest length between neighbouring points along x (0.9375 in Q16.16).
  localparam logic [COORD_W-1:0] REST_LEN = 32'h0000_F000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Floor of the signed mean of two coordinates; the extra bit keeps the sum exact.
  function automatic logic [COORD_W-1:0] half_sum(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {a[COORD_W-1], a} + {b[COORD_W-1], b};
    return s[COORD_W:1];
  endfunction

endpackage

// File: rtl/constraint_sweeper_enforce.sv
// Combinational damped constraint: moves cur halfway toward the point its
// neighbours want it at (their midpoint, or rest length past up for the tail).
module enforce_constraint
  import constraint_sweeper_pkg::*;
(
  input  logic [COORD_W-1:0] up_x,
  input  logic [COORD_W-1:0] up_y,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [COORD_W-1:0] down_x,
  input  logic [COORD_W-1:0] down_y,
  input  logic               is_last,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
);

  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;

  always_comb begin
    tgt_x = half_sum(up_x, down_x);
    tgt_y = half_sum(up_y, down_y);
    if (is_last) begin
      tgt_x = up_x + REST_LEN;
      tgt_y = up_y;
    end
    out_x = half_sum(cur_x, tgt_x);
    out_y = half_sum(cur_y, tgt_y);
  end

endmodule

// File: rtl/constraint_sweeper.sv
// Gauss-Seidel relaxation of a point chain anchored at point 0: each point
// takes LOAD/EVAL/WRITE (3 cycles) per sweep, ITERATIONS sweeps per start.
module constraint_sweeper
  import constraint_sweeper_pkg::*;
#(
  parameter int NUM_POINTS = 16,
  parameter int ITERATIONS = 4,
  parameter int IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [31:0]        wr_x,
  input  logic [31:0]        wr_y,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [31:0]        rd_x,
  output logic [31:0]        rd_y,
  output logic [1:0]         dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_POINTS - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX  = IDX_W'(1);
  localparam int               LAST_SWEEP = (ITERATIONS > 0) ? ITERATIONS - 1 : 0;
  localparam logic [15:0]      SWEEP_LAST = 16'(LAST_SWEEP);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        sweep_q, sweep_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] up_x_q, up_x_d, up_y_q, up_y_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] down_x_q, down_x_d, down_y_q, down_y_d;
  logic               is_last_q, is_last_d;
  logic [COORD_W-1:0] pts_x_q [NUM_POINTS];
  logic [COORD_W-1:0] pts_y_q [NUM_POINTS];
  logic [COORD_W-1:0] pts_x_d [NUM_POINTS];
  logic [COORD_W-1:0] pts_y_d [NUM_POINTS];
  logic [COORD_W-1:0] enf_x, enf_y;

  enforce_constraint u_enforce (
    .up_x    (up_x_q),
    .up_y    (up_y_q),
    .cur_x   (cur_x_q),
    .cur_y   (cur_y_q),
    .down_x  (down_x_q),
    .down_y  (down_y_q),
    .is_last (is_last_q),
    .out_x   (enf_x),
    .out_y   (enf_y)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    up_x_d    = up_x_q;
    up_y_d    = up_y_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    down_x_d  = down_x_q;
    down_y_d  = down_y_q;
    is_last_d = is_last_q;
    pts_x_d   = pts_x_q;
    pts_y_d   = pts_y_q;
    case (state_q)
      ST_IDLE: begin
        // Host write lands on the same edge as start, so the run sees it.
        if (wr_en && (int'(wr_idx) < NUM_POINTS)) begin
          pts_x_d[wr_idx] = wr_x;
          pts_y_d[wr_idx] = wr_y;
        end
        if (start) begin
          if (ITERATIONS == 0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = FIRST_IDX;
            sweep_d = '0;
          end
        end
      end
      ST_LOAD: begin
        up_x_d    = pts_x_q[idx_q - FIRST_IDX];
        up_y_d    = pts_y_q[idx_q - FIRST_IDX];
        cur_x_d   = pts_x_q[idx_q];
        cur_y_d   = pts_y_q[idx_q];
        is_last_d = (idx_q == LAST_IDX);
        if (idx_q == LAST_IDX) begin
          down_x_d = pts_x_q[idx_q - FIRST_IDX];
          down_y_d = pts_y_q[idx_q - FIRST_IDX];
        end else begin
          down_x_d = pts_x_q[idx_q + FIRST_IDX];
          down_y_d = pts_y_q[idx_q + FIRST_IDX];
        end
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        pts_x_d[idx_q] = enf_x;
        pts_y_d[idx_q] = enf_y;
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + FIRST_IDX;
          state_d = ST_LOAD;
        end else if (sweep_q != SWEEP_LAST) begin
          idx_d   = FIRST_IDX;
          sweep_d = sweep_q + 16'd1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= FIRST_IDX;
      sweep_q   <= '0;
      done_q    <= 1'b0;
      up_x_q    <= '0;
      up_y_q    <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      down_x_q  <= '0;
      down_y_q  <= '0;
      is_last_q <= 1'b0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        pts_x_q[i] <= '0;
        pts_y_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sweep_q   <= sweep_d;
      done_q    <= done_d;
      up_x_q    <= up_x_d;
      up_y_q    <= up_y_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      down_x_q  <= down_x_d;
      down_y_q  <= down_y_d;
      is_last_q <= is_last_d;
      pts_x_q   <= pts_x_d;
      pts_y_q   <= pts_y_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
  assign rd_x      = (int'(rd_idx) < NUM_POINTS) ? pts_x_q[rd_idx] : '0;
  assign rd_y      = (int'(rd_idx) < NUM_POINTS) ? pts_y_q[rd_idx] : '0;

endmodule
